bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: slave-wait cycles before an aborted transaction, range 1..65535.
REQ-002 The block SHALL have parameter TIMEOUT_DAT, default 8'hFF: read data returned on timeout.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be as follows; all outputs are registered.
- i_clk  in  1  clock
- i_reset  in  1  async active-high reset
- i_m0_addr  in  16  master 0 (UART master) address
- i_m0_dat  in  8  master 0 write data
- i_m0_we  in  1  master 0 write enable
- i_m0_cs  in  1  master 0 request
- o_m0_dat  out  8  master 0 read data
- o_m0_ack  out  1  master 0 acknowledge, one-cycle pulse
- i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs  in  16/8/1/1  master 1, same meaning as master 0
- o_m1_dat, o_m1_ack  out  8/1  master 1, same meaning as master 0
- o_s_addr  out  16  slave address
- o_s_dat  out  8  slave write data
- o_s_we  out  1  slave write enable
- o_s_cs  out  1  slave select
- i_s_dat  in  8  slave read data
- i_s_ack  in  1  slave acknowledge
- o_timeout  out  1  one-cycle pulse on aborted transaction

Function
REQ-005 Masters SHALL hold cs, addr, dat and we stable from request until ack, and SHALL drop cs in the cycle after ack.
REQ-006 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-007 In IDLE with no request: o_s_cs=0, o_s_we=0, and o_s_addr/o_s_dat hold their last values.
REQ-008 In IDLE with any cs high (cycle N), the FSM SHALL select the grant, latch that master's addr/dat/we into o_s_*, set o_s_cs=1 and enter BUSY; o_s_cs is visible at N+1.
REQ-009 With one requester, that requester SHALL be granted.
REQ-010 With both requesting, the master not granted last SHALL be granted (round-robin).
REQ-011 The last-grant pointer SHALL reset to 1, so master 0 wins the first contention.
REQ-012 In BUSY, o_s_* SHALL stay constant and the granted master's cs SHALL be ignored; a mid-transaction cs drop does not abort.
REQ-013 In BUSY, the wait counter SHALL clear on entry and increment once per cycle without i_s_ack.
REQ-014 When i_s_ack is high in BUSY at cycle M:
- at M+1: granted o_mX_ack=1, o_mX_dat=i_s_dat sampled at M (sampled also for writes), o_s_cs=0, o_s_we=0
- state goes to DONE.
REQ-015 When the counter reaches TIMEOUT without ack, the next cycle SHALL show ack to the granted master, o_mX_dat=TIMEOUT_DAT, o_s_cs=0, o_timeout=1, and the state goes to DONE.
REQ-016 If i_s_ack and timeout coincide in the same cycle, the ack SHALL win: slave data returned, no o_timeout.
REQ-017 DONE SHALL last exactly one cycle with ack deasserted, then return to IDLE; the earliest next o_s_cs is M+3 after the prior slave ack.
REQ-018 The non-granted master's ack SHALL stay 0 and its o_mX_dat SHALL hold its previous value.
REQ-019 The last-grant pointer SHALL update at grant time only.
REQ-020 An i_s_ack outside BUSY SHALL be ignored.

Reset
REQ-021 On i_reset the block SHALL immediately set:
- state=IDLE
- o_s_addr=0, o_s_dat=0, o_s_we=0, o_s_cs=0
- o_m0_dat=o_m1_dat=0, o_m0_ack=o_m1_ack=0
- o_timeout=0, counter=0, last-grant=1
REQ-022 Reset mid-transaction SHALL abort it without ack; after release the block restarts in IDLE.

Structure
REQ-023 Package bus_pkg SHALL hold ADDR_W=16, DATA_W=8 and the FSM state typedef {IDLE, BUSY, DONE}.
REQ-024 The round-robin grant logic SHALL be sub-module bus_rr_arb2: inputs req[1:0] and last; output grant index.
REQ-025 The counter width SHALL be derived from TIMEOUT, sized for at least 16 bits at maximum.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single write: m0 cs, addr=16'h1234, dat=8'hA5, we=1; slave acks 2 cycles after o_s_cs -> o_s_* match at N+1, o_m0_ack pulse 1 cycle, o_m1_ack=0.
- Single read: m1 read addr=16'h00FF; slave returns 8'h3C with ack -> o_m1_dat=8'h3C with o_m1_ack one cycle after i_s_ack.
- Contention: both cs in the same cycle, repeated 3 times after reset -> grant order m0, m1, m0, with no overlap on o_s_cs.
- Timeout: TIMEOUT=4, slave never acks -> after 4 BUSY cycles, o_m0_ack=1, o_m0_dat=8'hFF, o_timeout=1, then the next request is served normally.
- Ack/timeout coincidence: TIMEOUT=4 with i_s_ack on the 4th cycle -> slave data returned, o_timeout stays 0.
- Reset in BUSY: assert i_reset while o_s_cs=1 -> all outputs 0 immediately, no ack; after release, m0 wins contention.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared widths, FSM state type and sizing helper
// for the two-master bus arbiter.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// One request/acknowledge bus link: requester drives
// the master side, responder the slave side.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdat;
  logic              we;
  logic              cs;
  logic [DATA_W-1:0] rdat;
  logic              ack;

  modport master (
    output addr, wdat, we, cs,
    input  rdat, ack
  );

  modport slave (
    input  addr, wdat, we, cs,
    output rdat, ack
  );

endinterface

// File: rtl/bus_rr_arb2.sv
// Two-way round-robin pick: under contention the
// master that did not win last time is chosen.
module bus_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = last;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = last;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-slave arbiter with round-robin
// grant, slave wait timeout and registered outputs.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DAT = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_dat,
  input  logic              i_m0_we,
  input  logic              i_m0_cs,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_dat,
  input  logic              i_m1_we,
  input  logic              i_m1_cs,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_dat,
  output logic              o_s_we,
  output logic              o_s_cs,
  input  logic [DATA_W-1:0] i_s_dat,
  input  logic              i_s_ack,
  output logic              o_timeout
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_dat_q, s_dat_d;
  logic              s_we_q, s_we_d;
  logic              s_cs_q, s_cs_d;
  logic [DATA_W-1:0] m0_dat_q, m0_dat_d;
  logic [DATA_W-1:0] m1_dat_q, m1_dat_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic              tmo_q, tmo_d;
  logic              rr_gnt;

  bus_rr_arb2 u_rr (
    .req   ({i_m1_cs, i_m0_cs}),
    .last  (last_q),
    .grant (rr_gnt)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    s_addr_d = s_addr_q;
    s_dat_d  = s_dat_q;
    s_we_d   = s_we_q;
    s_cs_d   = s_cs_q;
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_cs_d = 1'b0;
        s_we_d = 1'b0;
        if (i_m0_cs || i_m1_cs) begin
          state_d  = BUSY;
          last_d   = rr_gnt;
          cnt_d    = '0;
          s_cs_d   = 1'b1;
          s_addr_d = rr_gnt ? i_m1_addr : i_m0_addr;
          s_dat_d  = rr_gnt ? i_m1_dat : i_m0_dat;
          s_we_d   = rr_gnt ? i_m1_we : i_m0_we;
        end
      end
      BUSY: begin
        // slave ack takes priority over an expiring wait
        if (i_s_ack) begin
          state_d = DONE;
          s_cs_d  = 1'b0;
          s_we_d  = 1'b0;
          if (last_q) begin
            m1_ack_d = 1'b1;
            m1_dat_d = i_s_dat;
          end else begin
            m0_ack_d = 1'b1;
            m0_dat_d = i_s_dat;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            s_cs_d  = 1'b0;
            s_we_d  = 1'b0;
            tmo_d   = 1'b1;
            if (last_q) begin
              m1_ack_d = 1'b1;
              m1_dat_d = TIMEOUT_DAT;
            end else begin
              m0_ack_d = 1'b1;
              m0_dat_d = TIMEOUT_DAT;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      s_addr_q <= '0;
      s_dat_q  <= '0;
      s_we_q   <= 1'b0;
      s_cs_q   <= 1'b0;
      m0_dat_q <= '0;
      m1_dat_q <= '0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      s_addr_q <= s_addr_d;
      s_dat_q  <= s_dat_d;
      s_we_q   <= s_we_d;
      s_cs_q   <= s_cs_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_s_addr  = s_addr_q;
  assign o_s_dat   = s_dat_q;
  assign o_s_we    = s_we_q;
  assign o_s_cs    = s_cs_q;
  assign o_m0_dat  = m0_dat_q;
  assign o_m1_dat  = m1_dat_q;
  assign o_m0_ack  = m0_ack_q;
  assign o_m1_ack  = m1_ack_q;
  assign o_timeout = tmo_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random
// rounds against a transaction-level arbiter model.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int         TMO  = 4;
  localparam logic [7:0] TDAT = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  logic tmo;

  bus_arbiter_if m0_if ();
  bus_arbiter_if m1_if ();
  bus_arbiter_if s_if ();

  int checks = 0;
  int errors = 0;
  int last_m;
  logic [7:0]  exp_dat [2];
  logic [15:0] a_r [2];
  logic [7:0]  d_r [2];
  logic        w_r [2];
  logic [7:0]  srd [2];

  always #5 clk = ~clk;

  bus_arbiter #(
    .TIMEOUT     (TMO),
    .TIMEOUT_DAT (TDAT)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_m0_addr (m0_if.addr),
    .i_m0_dat  (m0_if.wdat),
    .i_m0_we   (m0_if.we),
    .i_m0_cs   (m0_if.cs),
    .o_m0_dat  (m0_if.rdat),
    .o_m0_ack  (m0_if.ack),
    .i_m1_addr (m1_if.addr),
    .i_m1_dat  (m1_if.wdat),
    .i_m1_we   (m1_if.we),
    .i_m1_cs   (m1_if.cs),
    .o_m1_dat  (m1_if.rdat),
    .o_m1_ack  (m1_if.ack),
    .o_s_addr  (s_if.addr),
    .o_s_dat   (s_if.wdat),
    .o_s_we    (s_if.we),
    .o_s_cs    (s_if.cs),
    .i_s_dat   (s_if.rdat),
    .i_s_ack   (s_if.ack),
    .o_timeout (tmo)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  function automatic logic [7:0] dat_of(input int m);
    return (m == 0) ? m0_if.rdat : m1_if.rdat;
  endfunction

  // round-robin rule: alone wins, else the one not served last
  function automatic int pick(input logic [1:0] p,
                              input int last);
    if (p == 2'b11) return 1 - last;
    return p[1] ? 1 : 0;
  endfunction

  task automatic set_cs(input int m, input logic v);
    if (m == 0) m0_if.cs = v;
    else        m1_if.cs = v;
  endtask

  task automatic load(input int m, input logic [15:0] a,
                      input logic [7:0] d, input logic we,
                      input logic [7:0] rd);
    a_r[m] = a;
    d_r[m] = d;
    w_r[m] = we;
    srd[m] = rd;
    if (m == 0) begin
      m0_if.addr = a; m0_if.wdat = d; m0_if.we = we;
    end else begin
      m1_if.addr = a; m1_if.wdat = d; m1_if.we = we;
    end
  endtask

  task automatic run_round(input logic [1:0] mask,
                           input int lat0, input int lat1,
                           input bit drop);
    logic [1:0] pend;
    logic [7:0] rexp;
    int w, o, lat, kend;
    pend = mask;
    for (int m = 0; m < 2; m++)
      if (mask[m]) set_cs(m, 1'b1);
    while (pend != 2'b00) begin
      w = pick(pend, last_m);
      o = 1 - w;
      last_m = w;
      lat = (w == 0) ? lat0 : lat1;
      kend = (lat < TMO) ? lat : TMO - 1;
      tick();
      check("grant_cs", s_if.cs, 1);
      check("grant_addr", s_if.addr, a_r[w]);
      check("grant_dat", s_if.wdat, d_r[w]);
      check("grant_we", s_if.we, w_r[w]);
      if (drop) set_cs(w, 1'b0);
      for (int k = 0; k <= kend; k++) begin
        s_if.rdat = (k == lat) ? srd[w] : 8'($urandom);
        s_if.ack  = (k == lat);
        tick();
        s_if.ack = 1'b0;
        if (k < kend) begin
          check("busy_cs", s_if.cs, 1);
          check("busy_addr", s_if.addr, a_r[w]);
          check("busy_ack", ack_of(w), 0);
        end
      end
      rexp = (lat < TMO) ? srd[w] : TDAT;
      check("win_ack", ack_of(w), 1);
      check("win_dat", dat_of(w), rexp);
      check("timeout", tmo, (lat >= TMO));
      check("end_cs", s_if.cs, 0);
      check("end_we", s_if.we, 0);
      check("lose_ack", ack_of(o), 0);
      check("lose_dat", dat_of(o), exp_dat[o]);
      exp_dat[w] = rexp;
      set_cs(w, 1'b0);
      pend[w] = 1'b0;
      tick();
      check("done_ack", ack_of(w), 0);
      check("done_tmo", tmo, 0);
      check("done_cs", s_if.cs, 0);
    end
    s_if.ack = 1'b1;
    tick();
    s_if.ack = 1'b0;
    check("idle_ack0", m0_if.ack, 0);
    check("idle_ack1", m1_if.ack, 0);
    check("idle_cs", s_if.cs, 0);
    check("idle_addr", s_if.addr, a_r[last_m]);
  endtask

  initial begin
    rst = 1'b1;
    m0_if.cs = 1'b0; m1_if.cs = 1'b0;
    s_if.ack = 1'b0; s_if.rdat = 8'h00;
    load(0, 16'h0, 8'h0, 1'b0, 8'h0);
    load(1, 16'h0, 8'h0, 1'b0, 8'h0);
    last_m = 1;
    exp_dat[0] = 8'h00;
    exp_dat[1] = 8'h00;
    #1;
    check("rst_cs", s_if.cs, 0);
    check("rst_addr", s_if.addr, 0);
    check("rst_ack0", m0_if.ack, 0);
    check("rst_dat1", m1_if.rdat, 0);
    check("rst_tmo", tmo, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    load(0, 16'h1234, 8'hA5, 1'b1, 8'h5A);
    run_round(2'b01, 2, 0, 1'b0);
    load(1, 16'h00FF, 8'h00, 1'b0, 8'h3C);
    run_round(2'b10, 0, 1, 1'b0);

    load(0, 16'hA000, 8'h01, 1'b1, 8'h71);
    load(1, 16'hB000, 8'h02, 1'b0, 8'h72);
    run_round(2'b11, 1, 0, 1'b0);
    run_round(2'b11, 0, 2, 1'b0);

    load(0, 16'hC0DE, 8'h33, 1'b0, 8'h44);
    run_round(2'b01, 9, 0, 1'b0);
    load(0, 16'hC0DF, 8'h34, 1'b0, 8'h45);
    run_round(2'b01, 1, 0, 1'b0);
    load(1, 16'hD00D, 8'h55, 1'b0, 8'h66);
    run_round(2'b10, 0, TMO - 1, 1'b0);

    load(1, 16'h0BAD, 8'h77, 1'b1, 8'h88);
    m1_if.cs = 1'b1;
    tick();
    check("pre_rst_cs", s_if.cs, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_cs", s_if.cs, 0);
    check("arst_addr", s_if.addr, 0);
    check("arst_dat", s_if.wdat, 0);
    check("arst_we", s_if.we, 0);
    check("arst_d0", m0_if.rdat, 0);
    check("arst_d1", m1_if.rdat, 0);
    check("arst_tmo", tmo, 0);
    m1_if.cs = 1'b0;
    tick();
    check("rst_noack", m1_if.ack, 0);
    rst = 1'b0;
    last_m = 1;
    exp_dat[0] = 8'h00;
    exp_dat[1] = 8'h00;
    tick();
    load(0, 16'h1111, 8'h11, 1'b1, 8'h21);
    load(1, 16'h2222, 8'h22, 1'b1, 8'h22);
    run_round(2'b11, 0, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++)
        load(m, 16'($urandom), 8'($urandom),
             1'($urandom), 8'($urandom));
      run_round(2'($urandom_range(1, 3)),
                $urandom_range(0, 6),
                $urandom_range(0, 6),
                ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
